forex_update_tx: RTL
====================

# forex_update_tx

Avalon-MM write master that sends exchange-rate edge updates to the FOREX arbitrage peripheral. Producers push `(src, dst, weight)` updates into an internal FIFO through a valid/ready port. The block turns each update into the peripheral's two-word write sequence: register 0 carries the packed src/dst pair, register 1 carries the weight. It sits between the update source (the HPS bridge shim or a replay engine) and the peripheral's slave port.

## Interface

Parameters:
- `PRED_BITS`, default 8: width of one vertex index.
- `WEIGHT_BITS`, default 32: edge weight width, equal to the Avalon data width. Must satisfy 2*PRED_BITS ≤ WEIGHT_BITS.
- `FIFO_DEPTH`, default 8: number of update entries. Must be a power of two, ≥ 2.

Ports:
- `clk` input 1: single clock.
- `reset_n` input 1: reset; one clock, reset is asynchronous and active-low.
- `in_valid` input 1: an update is offered.
- `in_ready` output 1: the FIFO can accept an update.
- `in_src` input PRED_BITS: source vertex.
- `in_dst` input PRED_BITS: destination vertex.
- `in_weight` input WEIGHT_BITS: edge weight.
- `avm_chipselect` output 1: slave select.
- `avm_write` output 1: write strobe.
- `avm_address` output 3: register index (0 or 1).
- `avm_writedata` output WEIGHT_BITS: write data.
- `avm_waitrequest` input 1: slave stall.
- `busy` output 1: FIFO is non-empty or a write is in flight.
- `level` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `sent` output 16: completed-update counter.

## Operation

- **Push.** An update is accepted on a clk edge when `in_valid && in_ready`. `in_ready` = !full, and it is combinational from the registered occupancy.
- **No full bypass.** A push is never accepted while the FIFO is full, even if a pop happens in the same cycle.
- **State machine.** States are IDLE, PAIR, WEIGHT.
  - IDLE → PAIR when the FIFO is non-empty. Head data is loaded into the output registers.
  - PAIR: drives address 0 with data {zero-pad, src, dst}. src occupies [2*PRED_BITS-1:PRED_BITS] and dst occupies [PRED_BITS-1:0]. The upper bits are 0.
  - PAIR → WEIGHT on a completed beat. A beat completes on a cycle with `avm_write && !avm_waitrequest`.
  - WEIGHT: drives address 1 with data = weight.
  - On weight completion the FIFO head is popped and `sent` increments (wrapping at 16 bits).
  - After that pop, the next state is PAIR if entries remain, else IDLE.
- **Stall handling.** While `avm_waitrequest`=1, address, data, write and chipselect hold their values unchanged.
- **Avalon signal pairing.** `avm_chipselect` = `avm_write` at all times.
- **Cancellation.** A beat is never cancelled once asserted.
- **Simultaneous push and pop.** Push and pop in the same cycle leaves `level` unchanged.
- **Pointer wrap.** FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- **Reset values.** Reset may assert at any time, including mid-beat. All outputs go to 0 at once: `avm_write`, `avm_chipselect`, `avm_address`, `avm_writedata`, `busy`, `level`, `sent`. The FIFO is emptied, the state returns to IDLE and the queued updates are discarded.

## Timing

- All Avalon outputs are registered.
- **First-write latency.** An update pushed at edge N into an idle, empty block drives `avm_write`=1 (address 0) during the cycle after edge N+1.
- **Throughput.** With waitrequest=0, back-to-back updates take 2 cycles each. There is no idle cycle between WEIGHT and the next PAIR.
- **Stall effect.** Each cycle of waitrequest=1 adds exactly one cycle to the current beat.
- **`level` timing.** `level` updates on the edge of the push or pop.
- **`busy` timing.** `busy` is registered and falls on the edge after the last pop.

## Configuration

Macro: `FOREX_TX_DEDUP_EN`.

- **Defined.**
  - The block keeps the last transmitted {src, dst} plus a valid flag. The flag is cleared by reset.
  - When the head's pair equals the stored pair and the flag is set, PAIR is skipped: IDLE or WEIGHT-completion goes straight to WEIGHT. Throughput for repeated pairs is 1 cycle per update.
  - The stored pair updates on each completed PAIR beat.
- **Undefined.** Every update emits both beats, and the comparison logic is absent.

## Test plan

- **Single update.** Push src=3, dst=5, weight=0x0000_1234 with waitrequest=0.
  - Expect writes addr0 data 0x0000_0305, then addr1 data 0x0000_1234, on consecutive cycles.
  - Expect `sent`=1 and `busy`=0 afterwards.
- **Fill and drain.** With waitrequest held 1, push 9 updates.
  - Expect `in_ready`=0 after the 8th and `level`=8; the 9th is not accepted.
  - Release waitrequest: expect 16 beats in push order, 2 cycles per update, and `sent`=8.
- **Stall mid-beat.** Hold waitrequest=1 for 3 cycles during the addr1 beat.
  - Expect address and data stable for 4 cycles and exactly one completed beat.
- **Reset mid-beat.** Assert reset_n=0 during the addr0 beat with 4 entries queued.
  - Expect all outputs 0 asynchronously, with `level`=0.
  - After release, no writes occur until a new push.
- **Dedup.** Push (2,7,1),(2,7,2),(2,8,3).
  - With `FOREX_TX_DEDUP_EN`: beats are addr0, addr1, addr1, addr0, addr1.
  - Without it: 6 beats.
- **Simultaneous push/pop.** Push during every cycle of a drain at level=4.
  - Expect `level` to stay 4 across each WEIGHT completion.

Source files
------------

// File: rtl/forex_update_tx.sv
// forex_update_tx: Avalon-MM write master that drains a FIFO of (src, dst, weight) updates
// as a register-0 pair write followed by a register-1 weight write. Macro FOREX_TX_DEDUP_EN skips repeated pairs.
module forex_update_tx #(
    parameter int PRED_BITS   = 8,
    parameter int WEIGHT_BITS = 32,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PRED_BITS-1:0]        in_src,
    input  logic [PRED_BITS-1:0]        in_dst,
    input  logic [WEIGHT_BITS-1:0]      in_weight,
    output logic                        avm_chipselect,
    output logic                        avm_write,
    output logic [2:0]                  avm_address,
    output logic [WEIGHT_BITS-1:0]      avm_writedata,
    input  logic                        avm_waitrequest,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic [15:0]                 sent
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 2 * PRED_BITS;
    localparam int EW = PW + WEIGHT_BITS;

    typedef enum logic [1:0] {IDLE, PAIR, WEIGHT} state_t;

    state_t                 state, state_nx;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr, count;
    logic [AW-1:0]          rd_nxt_idx;
    logic                   full, empty, push, pop, beat, load, skip;
    logic [EW-1:0]          head_e, next_e, ld_e;
    logic                   wr_nx;
    logic [2:0]             addr_nx;
    logic [WEIGHT_BITS-1:0] data_nx;

    function automatic logic [WEIGHT_BITS-1:0] pack_pair(input logic [PW-1:0] pair);
        return WEIGHT_BITS'(pair);
    endfunction

    assign count      = wr_ptr - rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign level      = count;
    assign beat       = avm_write && !avm_waitrequest;
    assign rd_nxt_idx = rd_ptr[AW-1:0] + AW'(1);
    assign head_e     = mem[rd_ptr[AW-1:0]];
    // When the last queued entry is popped while a new one is pushed, forward the new one
    // straight to the output registers so there is no idle gap.
    assign next_e     = (count > (AW+1)'(1)) ? mem[rd_nxt_idx] : {in_src, in_dst, in_weight};
    assign ld_e       = (state == WEIGHT) ? next_e : head_e;

`ifdef FOREX_TX_DEDUP_EN
    logic [PW-1:0] last_pair;
    logic          last_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_vld  <= 1'b0;
            last_pair <= '0;
        end else if (state == PAIR && beat) begin
            last_vld  <= 1'b1;
            last_pair <= head_e[EW-1:WEIGHT_BITS];
        end
    end

    assign skip = last_vld && (ld_e[EW-1:WEIGHT_BITS] == last_pair);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        wr_nx    = avm_write;
        addr_nx  = avm_address;
        data_nx  = avm_writedata;
        pop      = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: load = !empty;
            PAIR: begin
                if (beat) begin
                    state_nx = WEIGHT;
                    addr_nx  = 3'd1;
                    data_nx  = head_e[WEIGHT_BITS-1:0];
                end
            end
            WEIGHT: begin
                if (beat) begin
                    pop = 1'b1;
                    if (count > (AW+1)'(1) || push) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        wr_nx    = 1'b0;
                        addr_nx  = '0;
                        data_nx  = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            wr_nx = 1'b1;
            if (skip) begin
                state_nx = WEIGHT;
                addr_nx  = 3'd1;
                data_nx  = ld_e[WEIGHT_BITS-1:0];
            end else begin
                state_nx = PAIR;
                addr_nx  = 3'd0;
                data_nx  = pack_pair(ld_e[EW-1:WEIGHT_BITS]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            busy           <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            sent           <= '0;
        end else begin
            state          <= state_nx;
            avm_write      <= wr_nx;
            avm_chipselect <= wr_nx;
            avm_address    <= addr_nx;
            avm_writedata  <= data_nx;
            busy           <= !empty || avm_write;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                sent   <= sent + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_src, in_dst, in_weight};
    end
endmodule
